// File: rtl/sram_axil_pkg.sv
// sram_axil_pkg
// Shared definitions for the SRAM control AXI4-Lite register slave:
//   RESP_OKAY / RESP_SLVERR  AXI response codes
//   w_state_t / r_state_t    write and read handshake FSM states
//   idx_in_range()           word-index bounds check against NUM_REGS
package sram_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // True when a decoded word index names an implemented register.
  function automatic logic idx_in_range(input int idx, input int num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/sram_axil_regfile.sv
// sram_axil_regfile
// NUM_REGS x 32-bit byte-strobed register storage.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset (clears all registers)
//   wr_en, wr_idx, wr_data, wr_strb write port; byte b is written only when wr_strb[b] is set
//   rd_idx, rd_data                 combinational read port; an unimplemented index reads as 0
//   reg_q                           flat register contents, register i in bits [32i+31:32i]
module sram_axil_regfile
  import sram_axil_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [31:0]             wr_data,
  input  logic [3:0]              wr_strb,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [31:0]             rd_data,
  output logic [32*NUM_REGS-1:0]  reg_q
);

  logic [31:0] mem [NUM_REGS];

  // The index is compared against each implemented register, so an
  // out-of-range index simply matches nothing and the write is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (int'(wr_idx) == i) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) mem[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Same match-based decode on the read side: unimplemented indices read 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_idx) == i) rd_data = mem[i];
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[32*i +: 32] = mem[i];
  end

endmodule

// File: rtl/sram_axil_slave.sv
// sram_axil_slave
// AXI4-Lite responder for the S00_AXI port of the SRAM control IP, backed by
// a byte-strobed 32-bit register file whose contents are exported on reg_q.
// One outstanding write and one outstanding read; the channels are independent.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn   clock, asynchronous active-low reset
//   s00_axi_aw* / w* / b*            write address, data and response channels
//   s00_axi_ar* / r*                 read address and data channels
//   reg_q                            flat register contents for the SRAM datapath
// Build option:
//   SRAM_AXIL_SLVERR_EN  when defined, out-of-range accesses respond SLVERR
//                        instead of OKAY (the data effect is the same either way)
module sram_axil_slave
  import sram_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [32*NUM_REGS-1:0]          reg_q
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

`ifdef SRAM_AXIL_SLVERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  w_state_t          w_state;
  r_state_t          r_state;
  logic              aw_hold, w_hold;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;

  logic              aw_fire, w_fire, ar_fire;
  logic              aw_have, w_have, commit;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [31:0]       wr_data, rd_data;
  logic [3:0]        wr_strb;
  logic              wr_in_range, rd_in_range, wr_en;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_fire = s00_axi_awvalid && s00_axi_awready;
  assign w_fire  = s00_axi_wvalid  && s00_axi_wready;
  assign ar_fire = s00_axi_arvalid && s00_axi_arready;

  // A channel counts as present if it was latched earlier or handshakes now,
  // so the commit happens on the edge of whichever of AW/W arrives last.
  assign aw_have = aw_hold || aw_fire;
  assign w_have  = w_hold  || w_fire;
  assign commit  = (w_state == W_IDLE) && aw_have && w_have;

  assign wr_idx  = aw_fire ? s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data = w_fire  ? s00_axi_wdata : w_data_q;
  assign wr_strb = w_fire  ? s00_axi_wstrb : w_strb_q;
  assign rd_idx  = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

  assign wr_in_range = idx_in_range(int'(wr_idx), NUM_REGS);
  assign rd_in_range = idx_in_range(int'(rd_idx), NUM_REGS);
  assign wr_en       = commit && wr_in_range;

  sram_axil_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .reg_q   (reg_q)
  );

  // Write FSM. Ready outputs are registered from next-cycle hold flags so
  // each channel stops accepting as soon as its beat has been latched.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state         <= W_IDLE;
      aw_hold         <= 1'b0;
      w_hold          <= 1'b0;
      aw_idx_q        <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) aw_idx_q <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
          if (w_fire) begin
            w_data_q <= s00_axi_wdata;
            w_strb_q <= s00_axi_wstrb;
          end
          if (commit) begin
            aw_hold         <= 1'b0;
            w_hold          <= 1'b0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b1;
            s00_axi_bresp   <= wr_in_range ? RESP_OKAY : OOR_RESP;
            w_state         <= W_RESP;
          end else begin
            aw_hold         <= aw_have;
            w_hold          <= w_have;
            s00_axi_awready <= !aw_have;
            s00_axi_wready  <= !w_have;
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            s00_axi_bvalid  <= 1'b0;
            s00_axi_awready <= 1'b1;
            s00_axi_wready  <= 1'b1;
            w_state         <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read FSM. The register file is sampled on the AR handshake edge, so a
  // write committing on that same edge is not yet visible to the read.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state         <= R_IDLE;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            s00_axi_rdata   <= rd_data;
            s00_axi_rresp   <= rd_in_range ? RESP_OKAY : OOR_RESP;
            s00_axi_rvalid  <= 1'b1;
            s00_axi_arready <= 1'b0;
            r_state         <= R_DATA;
          end else begin
            s00_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            s00_axi_rvalid  <= 1'b0;
            s00_axi_arready <= 1'b1;
            r_state         <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule
